// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture front-end.
//   PXW     : width of a converted pixel before zero-extension to the RAM width
//   FMT_*   : runtime pixel format codes driven on the fmt input
//   state_t : capture FSM state encoding
package cam_pkg;
  localparam int PXW = 12;

  localparam logic [1:0] FMT_RGB444     = 2'd0;
  localparam logic [1:0] FMT_RGB565_444 = 2'd1;
  localparam logic [1:0] FMT_RGB565_332 = 2'd2;
  localparam logic [1:0] FMT_Y8         = 2'd3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SYNC      = 3'd1,
    WAIT_LINE = 3'd2,
    BYTE1     = 3'd3,
    BYTE2     = 3'd4,
    END       = 3'd5
  } state_t;
endpackage

// File: rtl/cam_px_fmt.sv
// Combinational pixel packer: turns the two bytes of a camera pixel into a
// 12-bit pixel for the selected format.
//   b1  : first byte of the pixel (sampled while href high)
//   b2  : second byte of the pixel
//   fmt : format code (cam_pkg FMT_*)
//   px  : converted pixel, narrower formats zero-extended into the LSBs
module cam_px_fmt
  import cam_pkg::*;
(
  input  logic [7:0]     b1,
  input  logic [7:0]     b2,
  input  logic [1:0]     fmt,
  output logic [PXW-1:0] px
);
  always_comb begin
    px = '0;
    case (fmt)
      FMT_RGB444:     px = {b1[3:0], b2};
      // RGB565 -> RGB444: top 4 bits of each channel; green spans both bytes
      FMT_RGB565_444: px = {b1[7:4], b1[2:0], b2[7], b2[4:1]};
      // RGB565 -> RGB332
      FMT_RGB565_332: px = {4'b0, b1[7:5], b1[2:0], b2[4:3]};
      default:        px = {4'b0, b1};  // YUV422: Y is the first byte
    endcase
  end
endmodule

// File: rtl/cam_capture_px.sv
// Camera capture front-end. Samples the 8-bit pixel bus on CAM_pclk, pairs
// bytes into pixels, converts them to the latched format and writes them to
// the frame buffer through the dual-port RAM write port.
//   CAM_pclk, rst      : pixel clock, synchronous active-high reset
//   CAM_vsync/href     : frame sync (high between frames) / line valid
//   CAM_px_data        : pixel byte
//   cap_en, fmt        : capture enable (level), pixel format
//   DP_RAM_*           : registered write strobe/address/data, one cycle per pixel
//   frame_busy/done    : capture in progress / one-cycle end-of-frame pulse
//   frame_cnt          : completed frames (wraps)
//   line_err           : sticky line-length error, cleared at frame start
module cam_capture_px
  import cam_pkg::*;
#(
  parameter int H_PIX   = 160,
  parameter int V_LINES = 120,
  parameter int AW      = 15,
  parameter int DW      = 12
)(
  input  logic          CAM_pclk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  input  logic          cap_en,
  input  logic [1:0]    fmt,
  output logic          DP_RAM_regW,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          frame_busy,
  output logic          frame_done,
  output logic [7:0]    frame_cnt,
  output logic          line_err
);
  localparam int CW = $clog2(H_PIX + 1);
  localparam int LW = $clog2(V_LINES + 1);
  localparam logic [CW-1:0] H_MAX  = CW'(H_PIX);
  localparam logic [LW-1:0] V_MAX  = LW'(V_LINES);
  localparam logic [AW-1:0] H_STEP = AW'(H_PIX);

  state_t st, nxt;

  logic [1:0]     fmt_q;
  logic [7:0]     b1_q;
  logic [CW-1:0]  col_q;
  logic [LW-1:0]  line_q;
  logic [AW-1:0]  base_q;
  logic [PXW-1:0] px;

  // control strobes decoded from state + inputs
  logic start, cap_b1, px_in, line_end, odd_end, to_end;

  cam_px_fmt u_fmt (
    .b1  (b1_q),
    .b2  (CAM_px_data),
    .fmt (fmt_q),
    .px  (px)
  );

  // state register
  always_ff @(posedge CAM_pclk) begin
    if (rst) st <= IDLE;
    else     st <= nxt;
  end

  // next state; vsync high aborts any capture state
  always_comb begin
    nxt = st;
    case (st)
      IDLE:      if (cap_en && CAM_vsync) nxt = SYNC;
      SYNC:      if (!CAM_vsync) nxt = WAIT_LINE;
      WAIT_LINE: if (CAM_vsync) nxt = END;
                 else if (CAM_href) nxt = BYTE2;
      BYTE2:     if (CAM_vsync) nxt = END;
                 else if (CAM_href) nxt = BYTE1;
                 else nxt = WAIT_LINE;
      BYTE1:     if (CAM_vsync) nxt = END;
                 else if (CAM_href) nxt = BYTE2;
                 else nxt = WAIT_LINE;
      END:       nxt = cap_en ? SYNC : IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // outputs and datapath strobes
  always_comb begin
    frame_busy = 1'b0;
    frame_done = 1'b0;
    start      = 1'b0;
    cap_b1     = 1'b0;
    px_in      = 1'b0;
    line_end   = 1'b0;
    odd_end    = 1'b0;
    to_end     = 1'b0;
    case (st)
      SYNC: start = !CAM_vsync;
      WAIT_LINE: begin
        frame_busy = 1'b1;
        if (CAM_vsync) to_end = 1'b1;
        else if (CAM_href) cap_b1 = 1'b1;
      end
      BYTE2: begin
        frame_busy = 1'b1;
        if (CAM_vsync) to_end = 1'b1;
        else if (CAM_href) px_in = 1'b1;
        else begin
          line_end = 1'b1;
          odd_end  = 1'b1;  // line ended on byte 1: partial pixel dropped
        end
      end
      BYTE1: begin
        frame_busy = 1'b1;
        if (CAM_vsync) to_end = 1'b1;
        else if (CAM_href) cap_b1 = 1'b1;
        else line_end = 1'b1;
      end
      END: frame_done = 1'b1;
      default: ;
    endcase
  end

  // Lines past V_LINES are ignored entirely: no writes and no errors.
  logic line_ok, col_ok;
  assign line_ok = (line_q < V_MAX);
  assign col_ok  = (col_q < H_MAX);

  always_ff @(posedge CAM_pclk) begin
    if (rst) begin
      fmt_q          <= '0;
      b1_q           <= '0;
      col_q          <= '0;
      line_q         <= '0;
      base_q         <= '0;
      DP_RAM_regW    <= 1'b0;
      DP_RAM_addr_in <= '0;
      DP_RAM_data_in <= '0;
      frame_cnt      <= '0;
      line_err       <= 1'b0;
    end else begin
      DP_RAM_regW <= 1'b0;
      if (start) begin
        fmt_q    <= fmt;
        line_err <= 1'b0;
        col_q    <= '0;
        line_q   <= '0;
        base_q   <= '0;
      end
      if (cap_b1) b1_q <= CAM_px_data;
      if (px_in && line_ok) begin
        if (col_ok) begin
          DP_RAM_regW    <= 1'b1;
          DP_RAM_addr_in <= base_q + AW'(col_q);
          DP_RAM_data_in <= DW'(px);
          col_q          <= col_q + 1'b1;
        end else begin
          line_err <= 1'b1;  // pixel beyond H_PIX
        end
      end
      if (line_end) begin
        col_q <= '0;
        if (line_ok) begin
          line_q <= line_q + 1'b1;
          base_q <= base_q + H_STEP;
          if (odd_end || (col_q != '0 && col_ok)) line_err <= 1'b1;
        end
      end
      if (to_end) frame_cnt <= frame_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_cam_capture_px.sv
module tb_cam_capture_px;
  localparam int H = 4, V = 2, AW = 15, DW = 12;

  logic          CAM_pclk = 1'b0;
  logic          rst, CAM_vsync, CAM_href, cap_en;
  logic [7:0]    CAM_px_data;
  logic [1:0]    fmt;
  logic          DP_RAM_regW;
  logic [AW-1:0] DP_RAM_addr_in;
  logic [DW-1:0] DP_RAM_data_in;
  logic          frame_busy, frame_done, line_err;
  logic [7:0]    frame_cnt;

  cam_capture_px #(.H_PIX(H), .V_LINES(V), .AW(AW), .DW(DW)) dut (
    .CAM_pclk       (CAM_pclk),
    .rst            (rst),
    .CAM_vsync      (CAM_vsync),
    .CAM_href       (CAM_href),
    .CAM_px_data    (CAM_px_data),
    .cap_en         (cap_en),
    .fmt            (fmt),
    .DP_RAM_regW    (DP_RAM_regW),
    .DP_RAM_addr_in (DP_RAM_addr_in),
    .DP_RAM_data_in (DP_RAM_data_in),
    .frame_busy     (frame_busy),
    .frame_done     (frame_done),
    .frame_cnt      (frame_cnt),
    .line_err       (line_err)
  );

  always #5 CAM_pclk = ~CAM_pclk;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [1:0] f; logic [7:0] b1; logic [7:0] b2; logic [DW-1:0] px; } vec_t;

  wr_t  sb[$];
  vec_t vecs[8];
  int   checks = 0, errors = 0, done_cnt = 0;
  int   m_line = 0, m_frames = 0, m_done = 0;
  bit   m_open = 1'b0, m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // write monitor: every strobe must match the head of the scoreboard
  always @(negedge CAM_pclk) begin
    wr_t e;
    if (frame_done) done_cnt++;
    if (DP_RAM_regW) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h exp=none", DP_RAM_addr_in, DP_RAM_data_in);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(DP_RAM_addr_in), 32'(e.addr));
        chk("wr_data", 32'(DP_RAM_data_in), 32'(e.data));
      end
    end
  end

  task automatic frame_begin(input logic [1:0] f);
    fmt = f;
    CAM_vsync = 1'b1;
    repeat (2) @(negedge CAM_pclk);
    CAM_vsync = 1'b0;
    repeat (2) @(negedge CAM_pclk);
    m_open = cap_en;
    m_line = 0;
    m_err  = 1'b0;
    chk("busy_start", 32'(frame_busy), 32'(m_open));
    chk("err_cleared", 32'(line_err), 32'(m_err));
  endtask

  task automatic frame_end();
    CAM_vsync = 1'b1;
    repeat (3) @(negedge CAM_pclk);
    if (m_open) begin
      m_frames++;
      m_done++;
    end
    m_open = 1'b0;
    chk("done_pulses", 32'(done_cnt), 32'(m_done));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames[7:0]));
    chk("busy_end", 32'(frame_busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  // one byte on the bus; byte-2 positions push the expected write
  task automatic put_byte(input logic [7:0] d, input int idx, input logic [DW-1:0] px);
    @(negedge CAM_pclk);
    CAM_href = 1'b1;
    CAM_px_data = d;
    if ((idx % 2 == 1) && m_open && m_line < V && idx / 2 < H)
      sb.push_back('{addr: AW'(m_line * H + idx / 2), data: px});
  endtask

  task automatic send_line(input int nb, input logic [7:0] a, input logic [7:0] b, input logic [DW-1:0] px);
    int pairs;
    pairs = nb / 2;
    for (int i = 0; i < nb; i++) put_byte((i % 2 == 0) ? a : b, i, px);
    @(negedge CAM_pclk);
    CAM_href = 1'b0;
    CAM_px_data = 8'h00;
    @(negedge CAM_pclk);
    if (m_open && m_line < V) begin
      if ((nb % 2 != 0) || pairs > H || (pairs > 0 && pairs < H)) m_err = 1'b1;
      m_line++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'd0, 8'hA5, 8'h3C, 12'h53C};
    vecs[1] = '{2'd1, 8'hF8, 8'h00, 12'hF00};
    vecs[2] = '{2'd2, 8'hF8, 8'h00, 12'h0E0};
    vecs[3] = '{2'd3, 8'h7B, 8'h80, 12'h07B};
    vecs[4] = '{2'd1, 8'h07, 8'h9E, 12'h0FF};
    vecs[5] = '{2'd2, 8'h07, 8'h18, 12'h01F};
    vecs[6] = '{2'd0, 8'h12, 8'hEF, 12'h2EF};
    vecs[7] = '{2'd3, 8'hFF, 8'h00, 12'h0FF};

    rst = 1'b1; CAM_vsync = 1'b0; CAM_href = 1'b0; CAM_px_data = 8'h00;
    cap_en = 1'b1; fmt = 2'd0;
    repeat (3) @(negedge CAM_pclk);
    chk("rst_regW", 32'(DP_RAM_regW), 32'd0);
    chk("rst_addr", 32'(DP_RAM_addr_in), 32'd0);
    chk("rst_data", 32'(DP_RAM_data_in), 32'd0);
    chk("rst_busy", 32'(frame_busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_err", 32'(line_err), 32'd0);
    rst = 1'b0;

    // IDLE -> SYNC; no frame counted yet
    frame_end();

    // format table: two full lines per frame, fmt toggled mid-frame (ignored)
    foreach (vecs[k]) begin
      frame_begin(vecs[k].f);
      fmt = ~vecs[k].f;
      send_line(2 * H, vecs[k].b1, vecs[k].b2, vecs[k].px);
      send_line(2 * H, vecs[k].b1, vecs[k].b2, vecs[k].px);
      chk("busy_mid", 32'(frame_busy), 32'd1);
      chk("err_clean", 32'(line_err), 32'(m_err));
      frame_end();
    end

    // odd byte count: 2 writes, error, next line at address H
    frame_begin(2'd0);
    send_line(5, 8'hA5, 8'h3C, 12'h53C);
    chk("err_odd", 32'(line_err), 32'(m_err));
    send_line(2 * H, 8'hA5, 8'h3C, 12'h53C);
    frame_end();
    chk("err_sticky", 32'(line_err), 32'd1);

    // too many pixels: H writes, error
    frame_begin(2'd0);
    send_line(12, 8'h12, 8'hEF, 12'h2EF);
    chk("err_long", 32'(line_err), 32'(m_err));
    send_line(2 * H, 8'h12, 8'hEF, 12'h2EF);
    frame_end();

    // extra line past V: no writes, short third line raises no error
    frame_begin(2'd1);
    send_line(2 * H, 8'hF8, 8'h00, 12'hF00);
    send_line(2 * H, 8'hF8, 8'h00, 12'hF00);
    send_line(6, 8'hF8, 8'h00, 12'hF00);
    chk("err_past_v", 32'(line_err), 32'(m_err));
    frame_end();

    // cap_en dropped mid-frame: frame completes, next frame not captured
    frame_begin(2'd0);
    send_line(2 * H, 8'hA5, 8'h3C, 12'h53C);
    cap_en = 1'b0;
    send_line(2 * H, 8'hA5, 8'h3C, 12'h53C);
    frame_end();
    CAM_vsync = 1'b0;
    repeat (2) @(negedge CAM_pclk);
    chk("idle_busy", 32'(frame_busy), 32'd0);
    send_line(2 * H, 8'hA5, 8'h3C, 12'h53C);
    send_line(2 * H, 8'hA5, 8'h3C, 12'h53C);
    frame_end();
    cap_en = 1'b1;

    // vsync mid-line: in-flight pixel dropped, frame_done pulse
    frame_begin(2'd0);
    put_byte(8'hA5, 0, 12'h53C);
    put_byte(8'h3C, 1, 12'h53C);
    put_byte(8'hA5, 2, 12'h53C);
    @(negedge CAM_pclk);
    CAM_vsync = 1'b1;
    CAM_px_data = 8'h3C;
    @(negedge CAM_pclk);
    CAM_href = 1'b0;
    chk("abort_done", 32'(frame_done), 32'd1);
    chk("abort_busy", 32'(frame_busy), 32'd0);
    m_frames++; m_done++; m_open = 1'b0;
    repeat (2) @(negedge CAM_pclk);
    chk("abort_cnt", 32'(frame_cnt), 32'(m_frames[7:0]));
    chk("abort_sb", 32'(sb.size()), 32'd0);

    // reset mid-line: everything to zero, no write, no frame_done
    frame_begin(2'd0);
    put_byte(8'hA5, 0, 12'h53C);
    put_byte(8'h3C, 1, 12'h53C);
    put_byte(8'hA5, 2, 12'h53C);
    @(negedge CAM_pclk);
    rst = 1'b1;
    CAM_px_data = 8'h3C;
    @(negedge CAM_pclk);
    chk("mrst_regW", 32'(DP_RAM_regW), 32'd0);
    chk("mrst_addr", 32'(DP_RAM_addr_in), 32'd0);
    chk("mrst_data", 32'(DP_RAM_data_in), 32'd0);
    chk("mrst_busy", 32'(frame_busy), 32'd0);
    chk("mrst_done", 32'(frame_done), 32'd0);
    chk("mrst_cnt", 32'(frame_cnt), 32'd0);
    chk("mrst_err", 32'(line_err), 32'd0);
    CAM_href = 1'b0;
    m_open = 1'b0;
    repeat (2) @(negedge CAM_pclk);
    rst = 1'b0;
    repeat (3) @(negedge CAM_pclk);
    chk("mrst_no_done", 32'(done_cnt), 32'(m_done));
    chk("final_sb", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
